// File: rtl/mips16_imem_loader_if.sv
// Write-stream handshake carrying encoded MIPS16 instruction words into the loader.
interface mips16_imem_loader_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/mips16_imem_loader.sv
// Loads a MIPS16 program into instruction memory, pads the remainder, holds the
// core in reset until the image is complete, then serves registered fetches.
module mips16_imem_loader #(
  parameter int unsigned           PC_WIDTH   = 8,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           DEPTH      = 2**PC_WIDTH,
  parameter int unsigned           RST_HOLD   = 10,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic [PC_WIDTH:0]     load_len,
  mips16_imem_loader_if.slave   wr,
  output logic                  cpu_rst,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  busy,
  output logic [PC_WIDTH:0]     load_count,
  output logic                  err
);

  localparam int unsigned LEN_W  = PC_WIDTH + 1;
  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [LEN_W-1:0]  DEPTH_LEN = LEN_W'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FILL, HOLD, RUN} state_t;

  state_t                state, state_next;
  logic [PC_WIDTH-1:0]   addr;
  logic [LEN_W-1:0]      len;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic legal, start_ok, start_bad, accept, fill_we;

  assign legal = (load_len != '0) && (load_len <= DEPTH_LEN);

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    fill_we    = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (load_start) begin
          if (legal) begin
            start_ok   = 1'b1;
            state_next = LOAD;
          end else begin
            start_bad  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (wr.wr_valid) begin
          accept = 1'b1;
          // A full-depth load wraps addr back to 0, so there is nothing to pad.
          if (load_count + LEN_W'(1) == len)
            state_next = (len == DEPTH_LEN) ? HOLD : FILL;
        end
      end
      FILL: begin
        fill_we = 1'b1;
        if (addr == '1) state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decode straight from the state register so
  // they follow the asynchronous reset without an extra cycle.
  assign wr.wr_ready = (state == LOAD);
  assign cpu_rst     = (state != RUN);
  assign busy        = (state == LOAD) || (state == FILL) || (state == HOLD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      len        <= '0;
      hold_cnt   <= '0;
      load_count <= '0;
      err        <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
      if (start_ok) begin
        len        <= load_len;
        addr       <= '0;
        load_count <= '0;
        err        <= 1'b0;
      end else if (start_bad) begin
        err <= 1'b1;
      end
      if (accept) begin
        addr       <= addr + PC_WIDTH'(1);
        load_count <= load_count + LEN_W'(1);
      end
      if (fill_we) addr <= addr + PC_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept)       mem[addr] <= wr.wr_data;
    else if (fill_we) mem[addr] <= FILL_WORD;
  end

  // Keyed on the next state so a reload blanks instr from its first LOAD cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    instr <= '0;
    else if (state_next == RUN)  instr <= mem[pc];
    else                         instr <= '0;
  end

endmodule

// File: tb/tb_mips16_imem_loader.sv
// Directed bench: fetch expectations go to a scoreboard queue, a monitor checks instr.
module tb_mips16_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [8:0]  load_len;
  logic        cpu_rst;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        busy;
  logic [8:0]  load_count;
  logic        err;
  logic        fetch_v;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [$];
  string       name_q [$];

  mips16_imem_loader_if #(.DATA_WIDTH(16)) wr ();

  mips16_imem_loader #(
    .PC_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256), .RST_HOLD(10), .FILL_WORD(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .wr(wr.slave), .cpu_rst(cpu_rst), .pc(pc), .instr(instr), .busy(busy),
    .load_count(load_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each fetch strobe sampled at a clock edge yields instr just after it.
  always @(posedge clk) begin
    if (fetch_v) begin
      #1;
      if (exp_q.size() == 0) begin
        chk("fetch_unexpected", 32'(instr), 32'hFFFF_FFFF);
      end else begin
        chk(name_q.pop_front(), 32'(instr), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [8:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input int gap);
    int n = 0;
    wr.wr_valid = 1'b0;
    repeat (gap) @(negedge clk);
    wr.wr_valid = 1'b1;
    wr.wr_data  = w;
    while (!wr.wr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(wr.wr_ready), 32'd1);
    @(negedge clk);
    wr.wr_valid = 1'b0;
  endtask

  task automatic wait_run(input int exp_cycles, input string name);
    int n = 0;
    while (cpu_rst && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  task automatic fetch(input logic [7:0] p, input logic [15:0] exp, input string name);
    pc      = p;
    fetch_v = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    fetch_v = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; load_start = 1'b0; load_len = '0; pc = '0; fetch_v = 1'b0;
    wr.wr_valid = 1'b0; wr.wr_data = '0;
    tick(3);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_wr_ready", 32'(wr.wr_ready), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick(1);

    // Basic load of four words, back to back.
    start(9'd4);
    chk("t1_load_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t1_load_instr", 32'(instr), 32'd0);
    chk("t1_load_busy", 32'(busy), 32'd1);
    send(16'h1111, 0); send(16'h2222, 0); send(16'h3333, 0); send(16'h4444, 0);
    chk("t1_ready_drop", 32'(wr.wr_ready), 32'd0);
    chk("t1_load_count", 32'(load_count), 32'd4);
    wait_run(262, "t1_run_latency");
    chk("t1_run_busy", 32'(busy), 32'd0);
    fetch(8'd2, 16'h3333, "t1_pc2");
    fetch(8'd200, 16'h0000, "t1_pc200");
    fetch(8'd0, 16'h1111, "t1_pc0");
    fetch(8'd3, 16'h4444, "t1_pc3");
    fetch(8'd4, 16'h0000, "t1_pc4");

    // Backpressure: two idle cycles between words, reloaded from RUN.
    start(9'd3);
    send(16'h00A1, 0); send(16'h00A2, 2); send(16'h00A3, 2);
    chk("t2_ready_drop", 32'(wr.wr_ready), 32'd0);
    chk("t2_load_count", 32'(load_count), 32'd3);
    wait_run(263, "t2_run_latency");
    fetch(8'd0, 16'h00A1, "t2_pc0");
    fetch(8'd1, 16'h00A2, "t2_pc1");
    fetch(8'd2, 16'h00A3, "t2_pc2");
    fetch(8'd3, 16'h0000, "t2_pc3");

    // Full-depth load: straight to HOLD.
    start(9'd256);
    for (int i = 0; i < 256; i++) send(16'(i), 0);
    chk("t3_load_count", 32'(load_count), 32'd256);
    chk("t3_ready_drop", 32'(wr.wr_ready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    wait_run(10, "t3_run_latency");
    fetch(8'd255, 16'h00FF, "t3_pc255");
    fetch(8'd0, 16'h0000, "t3_pc0");
    fetch(8'd128, 16'h0080, "t3_pc128");

    // Illegal length while running: flag only, core keeps running.
    start(9'd300);
    chk("run_bad_err", 32'(err), 32'd1);
    chk("run_bad_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("run_bad_busy", 32'(busy), 32'd0);
    fetch(8'd255, 16'h00FF, "run_bad_pc255");

    // Reload of a single word from RUN.
    start(9'd1);
    chk("t6_err_clear", 32'(err), 32'd0);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_instr_zero", 32'(instr), 32'd0);
    send(16'hABCD, 0);
    chk("t6_instr_zero_fill", 32'(instr), 32'd0);
    wait_run(265, "t6_run_latency");
    fetch(8'd0, 16'hABCD, "t6_pc0");
    fetch(8'd1, 16'h0000, "t6_pc1");

    // Illegal lengths from IDLE.
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    start(9'd0);
    chk("t4_len0_err", 32'(err), 32'd1);
    chk("t4_len0_busy", 32'(busy), 32'd0);
    chk("t4_len0_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t4_len0_ready", 32'(wr.wr_ready), 32'd0);
    start(9'd300);
    chk("t4_len300_err", 32'(err), 32'd1);
    chk("t4_len300_busy", 32'(busy), 32'd0);

    // Legal load clears err; reset lands after two of five words.
    start(9'd5);
    chk("t5_err_clear", 32'(err), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    send(16'h0501, 0); send(16'h0502, 0);
    chk("t5_partial_count", 32'(load_count), 32'd2);
    rst = 1'b0;
    #1;
    chk("t5_async_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t5_async_ready", 32'(wr.wr_ready), 32'd0);
    chk("t5_async_count", 32'(load_count), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    start(9'd5);
    send(16'h5550, 0); send(16'h5551, 0); send(16'h5552, 0); send(16'h5553, 0); send(16'h5554, 0);
    chk("t5_load_count", 32'(load_count), 32'd5);
    wait_run(261, "t5_run_latency");
    fetch(8'd0, 16'h5550, "t5_pc0");
    fetch(8'd4, 16'h5554, "t5_pc4");
    fetch(8'd5, 16'h0000, "t5_pc5");

    tick(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips16_imem_loader.md
Name: mips16_imem_loader

Overview:
- Load-side counterpart to the bench's instruction encoder and reset driver.
- Accepts a stream of encoded 16-bit MIPS16 instruction words over a valid/ready handshake and writes them into a 256-entry instruction memory.
- Pads unused locations and holds the CPU in reset until loading completes, then releases it.
- Serves instruction fetches indexed by the CPU's pc, registered with one-cycle latency.

Parameters:
- PC_WIDTH, 8, fetch/memory address width (matches `PC_WIDTH).
- DATA_WIDTH, 16, instruction word width.
- DEPTH, 256, memory entries; always 2**PC_WIDTH.
- RST_HOLD, 10, cycles cpu_rst stays asserted after load/fill completes.
- FILL_WORD, 16'h0000, value written to every location not covered by the load.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load; sampled in IDLE and RUN only.
- load_len  in  9  number of words to load; sampled with load_start; legal range 1..256.
- wr_valid  in  1  wr_data holds a valid instruction word.
- wr_ready  out  1  loader accepts a word this cycle.
- wr_data  in  16  encoded instruction word.
- cpu_rst  out  1  active-high reset to the MIPS16 core.
- pc  in  8  fetch address from the core.
- instr  out  16  fetched instruction, registered.
- busy  out  1  high in LOAD, FILL and HOLD.
- load_count  out  9  words accepted in the current or most recent load.
- err  out  1  sticky illegal-length flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cpu_rst=1, wr_ready=0, instr=0, busy=0, load_count=0, err=0.
  - Internal write address and hold counter clear to 0.
  - Memory contents are not reset.
  - Release of rst is synchronous to clk.
- States: IDLE, LOAD, FILL, HOLD, RUN.
- IDLE: cpu_rst=1, instr=0.
  - load_start with load_len in 1..256: latch len, clear addr and load_count, clear err, go to LOAD next cycle.
  - load_start with load_len=0 or >256: set err=1, stay in IDLE.
- LOAD: wr_ready=1, cpu_rst=1.
  - A word is accepted only when wr_valid && wr_ready: mem[addr]<=wr_data, addr+1, load_count+1.
  - wr_valid low means no write and no progress; arbitrary gaps are allowed.
  - On the accept that makes load_count==len:
    - wr_ready drops the following cycle.
    - If len<DEPTH, go to FILL; if len==DEPTH, go directly to HOLD (addr wraps to 0, no FILL cycles).
- FILL: wr_ready=0. Write FILL_WORD to mem[addr], addr+1, one location per cycle, for DEPTH-len cycles, then go to HOLD.
- HOLD: cpu_rst=1 for exactly RST_HOLD cycles, then go to RUN.
- RUN: cpu_rst=0.
  - instr<=mem[pc] every cycle; the value presented on pc in cycle N appears on instr in cycle N+1.
  - load_start with legal load_len: cpu_rst=1 and instr=0 from the next cycle, go to LOAD (reload).
  - load_start with illegal load_len: err=1, stay in RUN, cpu_rst unchanged.
- Outside RUN, instr is forced to 0 (registered).
- load_start is ignored in LOAD, FILL and HOLD, and err is unaffected there.
- busy equals (state in {LOAD, FILL, HOLD}), registered together with the state.
- Width rules:
  - addr is PC_WIDTH bits and wraps modulo DEPTH.
  - load_count is 9 bits so it can reach 256 without overflow.
- Reset mid-operation (any state): immediate return to IDLE with cpu_rst=1. A partially written memory is left as is and is never fetched until a complete load finishes.
- Timing, with load_start in cycle 0:
  - LOAD begins in cycle 1.
  - Last accept in cycle k gives FILL in cycles k+1..k+DEPTH-len.
  - HOLD spans the next RST_HOLD cycles.
  - cpu_rst falls at the first RUN cycle.

Test Plan:
1. Reset, then load_start with load_len=4 and words 16'h1111, 2222, 3333, 4444 streamed back-to-back -> accepts in cycles 1-4, FILL cycles 5-256, HOLD cycles 257-266, cpu_rst=0 from cycle 267; pc=2 -> instr=16'h3333 next cycle; pc=200 -> instr=16'h0000.
2. Backpressure: load_len=3 with wr_valid low for 2 cycles between each word -> exactly 3 writes, load_count=3, data in order at addresses 0..2; wr_ready=0 from the cycle after the third accept.
3. Full load: load_len=256 with data equal to its index -> no FILL cycles, HOLD immediately after the last accept; pc=255 -> instr=16'h00FF; load_count=256.
4. Illegal length: load_len=0, then load_len=300 -> err=1, state stays IDLE, cpu_rst=1; a subsequent legal load_start clears err.
5. Reset mid-load: drive rst=0 after 2 of 5 words -> cpu_rst=1, wr_ready=0, load_count=0, busy=0 asynchronously; a new full load of 5 words then completes normally.
6. Reload from RUN: while in RUN, load_start with load_len=1 and word 16'hABCD -> cpu_rst=1 the next cycle, instr=0 during the load, after FILL and HOLD pc=0 -> instr=16'hABCD and pc=1 -> instr=16'h0000.
